bdd_sbox_phase_ctrl: RTL

- Sequencer for one 4-bit dual-rail precharged BDD S-box slice (four bdd_Sbox output-bit instances sharing select lines v0..v3).
- Accepts plaintext nibbles over valid/ready and runs precharge, select setup and evaluate phases on the S-box.
- Samples the uncomplemented/complemented rails, checks dual-rail integrity and returns the substituted nibble over valid/ready.
- Sits between the round datapath and the custom-cell S-box; the only clocked logic touching the S-box control nets.

---
 rtl/bdd_sbox_phase_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/bdd_sbox_phase_ctrl.sv
// Phase sequencer for a 4-bit dual-rail precharged BDD S-box slice: precharge, setup, evaluate, sample.
// Optional macro BDD_SBOX_FAULT_RETRY_EN: rerun the sequence once when the integrity check fails.
module bdd_sbox_phase_ctrl #(
    parameter int PRE_CYCLES  = 2,
    parameter int EVAL_CYCLES = 3,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_nibble,
    output logic [3:0] select,
    output logic [3:0] selectBar,
    output logic       pre,
    input  logic [3:0] uout,
    input  logic [3:0] cout,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_nibble,
    output logic       out_err,
    output logic [7:0] fault_cnt,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRECHARGE,
        S_SETUP,
        S_EVAL,
        S_HOLD
    } state_t;

    localparam logic [CNT_W-1:0] PRE_LOAD  = CNT_W'(PRE_CYCLES - 1);
    localparam logic [CNT_W-1:0] EVAL_LOAD = CNT_W'(EVAL_CYCLES - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic [3:0]       nibble;
    logic             pend;

    logic             accept;
    logic             cnt_zero;
    logic             pre_last;
    logic             eval_last;
    logic             rails_ok;
    logic             retry_now;

    logic             pre_d;
    logic             out_valid_d;
    logic [3:0]       select_d;
    logic [3:0]       select_bar_d;

    assign accept    = (state == S_IDLE) && in_valid;
    assign cnt_zero  = (cnt == '0);
    assign pre_last  = (state == S_PRECHARGE) && cnt_zero;
    assign eval_last = (state == S_EVAL) && cnt_zero;
    // A healthy slice drives exactly one rail high per bit, from a clean precharge.
    assign rails_ok  = ((uout ^ cout) == 4'hF) && !pend;

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

`ifdef BDD_SBOX_FAULT_RETRY_EN
    logic retried;

    assign retry_now = eval_last && !rails_ok && !retried;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retried <= 1'b0;
        end else if (accept) begin
            retried <= 1'b0;
        end else if (retry_now) begin
            retried <= 1'b1;
        end
    end
`else
    assign retry_now = 1'b0;
`endif

    // State and phase counter register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no latch is inferred.
    always_comb begin
        next_state = state;
        cnt_d      = cnt;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    next_state = S_PRECHARGE;
                    cnt_d      = PRE_LOAD;
                end
            end
            S_PRECHARGE: begin
                if (cnt_zero) begin
                    next_state = S_SETUP;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            S_SETUP: begin
                next_state = S_EVAL;
                cnt_d      = EVAL_LOAD;
            end
            S_EVAL: begin
                if (!cnt_zero) begin
                    cnt_d = cnt - CNT_W'(1);
                end else if (retry_now) begin
                    next_state = S_PRECHARGE;
                    cnt_d      = PRE_LOAD;
                end else begin
                    next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Control nets are decoded from the next state and then registered, so they are glitch-free.
    // Select lines only leave zero one cycle before pre rises (break-before-make).
    always_comb begin
        pre_d        = 1'b0;
        out_valid_d  = 1'b0;
        select_d     = 4'h0;
        select_bar_d = 4'h0;
        case (next_state)
            S_SETUP: begin
                select_d     = nibble;
                select_bar_d = ~nibble;
            end
            S_EVAL: begin
                pre_d        = 1'b1;
                select_d     = nibble;
                select_bar_d = ~nibble;
            end
            S_HOLD: begin
                out_valid_d = 1'b1;
            end
            default: begin
                pre_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre       <= 1'b0;
            select    <= 4'h0;
            selectBar <= 4'h0;
            out_valid <= 1'b0;
        end else begin
            pre       <= pre_d;
            select    <= select_d;
            selectBar <= select_bar_d;
            out_valid <= out_valid_d;
        end
    end

    // Operand latch, precharge check and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nibble     <= 4'h0;
            pend       <= 1'b0;
            out_nibble <= 4'h0;
            out_err    <= 1'b0;
            fault_cnt  <= 8'h00;
        end else begin
            if (accept) begin
                nibble <= in_nibble;
            end
            if (pre_last) begin
                pend <= |(uout | cout);
            end
            if (eval_last && !retry_now) begin
                out_nibble <= uout;
                out_err    <= !rails_ok;
            end
            if (eval_last && !rails_ok && (fault_cnt != 8'hFF)) begin
                fault_cnt <= fault_cnt + 8'd1;
            end
        end
    end

`ifndef SYNTHESIS
    a_no_overlap : assert property (@(posedge clk) disable iff (!rst_n)
        (select & selectBar) == 4'h0);
    a_pre_has_select : assert property (@(posedge clk) disable iff (!rst_n)
        pre |-> ((select ^ selectBar) == 4'hF));
`endif

endmodule
